rx_capture_ctrl: RTL and testbench

Inbound capture controller between the BiDir in-channel deserializer and the RX DMA (S2MM) stream. Buffers 32-bit inbound samples in an internal FIFO and freezes capture once the fill level reaches a programmable halt level. Drains to the DMA under register control, and re-arms on a software pulse. Supplies the RXFIFO_REG3 status word and consumes the RXFIFO_REG0 drain enable and RXFIFO_REG1 re-arm bits.

---
 rtl/rx_capture_pkg.sv | 32 +++
 rtl/rx_sync_fifo.sv | 100 ++++++++++
 rtl/rx_capture_ctrl.sv | 102 ++++++++++
 tb/tb_rx_capture_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rx_capture_pkg.sv
// rx_capture_pkg: state, status-word layout and defaults shared by the
// RX capture controller and its FIFO.
package rx_capture_pkg;

  typedef enum logic {
    CAPTURE = 1'b0,
    HALTED  = 1'b1
  } cap_state_e;

  localparam int DATA_W     = 32;
  localparam int HALT_BIT   = 31;
  localparam int EMPTY_BIT  = 30;
  localparam int FILL_LSB   = 0;
  localparam int FILL_FLD_W = 17;

  localparam int DEF_DEPTH      = 65536;
  localparam int DEF_HALT_LEVEL = 49152;

  function automatic logic [31:0] pack_status(
    input logic                  halted,
    input logic                  empty,
    input logic [FILL_FLD_W-1:0] fill
  );
    logic [31:0] s;
    s = '0;
    s[HALT_BIT] = halted;
    s[EMPTY_BIT] = empty;
    s[FILL_LSB +: FILL_FLD_W] = fill;
    return s;
  endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// rx_sync_fifo: single-clock FWFT FIFO with a registered RAM read
// stage feeding an output register.
module rx_sync_fifo
  import rx_capture_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int FILL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              fetch_i,
  input  logic              pop_i,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [FILL_W-1:0] fill_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [FILL_W-1:0] ram_cnt_q, ram_cnt_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] s1_q;
  logic [DATA_W-1:0] out_q, out_d;
  logic              s1_vld_q, s1_vld_d;
  logic              out_vld_q, out_vld_d;
  logic              wr, pop;
  logic              out_take, s1_move;
  logic              s1_free, ram_pop;

  // fill counts RAM, read stage and output register together
  always_comb begin
    wr        = wr_i && (fill_q != FILL_W'(DEPTH));
    pop       = pop_i && out_vld_q;
    out_take  = !out_vld_q || pop;
    s1_move   = s1_vld_q && out_take;
    s1_free   = !s1_vld_q || s1_move;
    ram_pop   = fetch_i && (ram_cnt_q != '0) && s1_free;
    wptr_d    = wptr_q + AW'(wr);
    rptr_d    = rptr_q + AW'(ram_pop);
    ram_cnt_d = ram_cnt_q + FILL_W'(wr) - FILL_W'(ram_pop);
    fill_d    = fill_q + FILL_W'(wr) - FILL_W'(pop);
    s1_vld_d  = s1_vld_q;
    out_vld_d = out_vld_q;
    out_d     = out_q;
    if (ram_pop) begin
      s1_vld_d = 1'b1;
    end else if (s1_move) begin
      s1_vld_d = 1'b0;
    end
    if (s1_move) begin
      out_vld_d = 1'b1;
      out_d     = s1_q;
    end else if (pop) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) begin
      mem_q[wptr_q] <= wdata_i;
    end
    if (ram_pop) begin
      s1_q <= mem_q[rptr_q];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      ram_cnt_q <= '0;
      fill_q    <= '0;
      s1_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ram_cnt_q <= ram_cnt_d;
      fill_q    <= fill_d;
      s1_vld_q  <= s1_vld_d;
      out_vld_q <= out_vld_d;
      out_q     <= out_d;
    end
  end

  assign rvalid_o = out_vld_q;
  assign rdata_o  = out_q;
  assign fill_o   = fill_q;
  assign empty_o  = (fill_q == '0);
  assign full_o   = (fill_q == FILL_W'(DEPTH));

endmodule

// File: rtl/rx_capture_ctrl.sv
// rx_capture_ctrl: capture-and-halt controller in front of the RX DMA.
// RX_CAPTURE_DROP_CNT_EN adds a saturating drop_count output.
module rx_capture_ctrl
  import rx_capture_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int HALT_LEVEL = DEF_HALT_LEVEL,
  parameter int FILL_W     = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        drain_en,
  input  logic        rearm,
  output logic        m_tvalid,
  output logic [31:0] m_tdata,
  output logic        m_tlast,
  input  logic        m_tready,
  output logic [31:0] status
`ifdef RX_CAPTURE_DROP_CNT_EN
  ,
  output logic [15:0] drop_count
`endif
);

  cap_state_e        state_q;
  logic [FILL_W-1:0] fill, fill_nx;
  logic [31:0]       rdata;
  logic              rvalid, empty, full;
  logic              wr, rd, rearm_ok;

  rx_sync_fifo #(
    .DEPTH  (DEPTH),
    .FILL_W (FILL_W)
  ) u_fifo (
    .clk_i    (clk),
    .rst_ni   (resetn),
    .wr_i     (wr),
    .wdata_i  (in_data),
    .fetch_i  (drain_en),
    .pop_i    (rd),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .fill_o   (fill),
    .empty_o  (empty),
    .full_o   (full)
  );

  always_comb begin
    wr       = in_valid && (state_q == CAPTURE) && !full;
    rd       = m_tvalid && m_tready;
    rearm_ok = (state_q == HALTED) && rearm && !drain_en;
    fill_nx  = fill + FILL_W'(wr) - FILL_W'(rd);
  end

  // a held output word is hidden while drain is off and shown again later
  assign m_tvalid = rvalid && drain_en;
  assign m_tdata  = rdata;
  assign m_tlast  = m_tvalid && (fill == FILL_W'(1));
  assign status   = pack_status(state_q == HALTED, empty,
                                FILL_FLD_W'(fill));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= CAPTURE;
    end else begin
      unique case (state_q)
        CAPTURE: begin
          if (wr && (fill_nx >= FILL_W'(HALT_LEVEL))) begin
            state_q <= HALTED;
          end
        end
        HALTED: begin
          if (rearm_ok) begin
            state_q <= CAPTURE;
          end
        end
      endcase
    end
  end

`ifdef RX_CAPTURE_DROP_CNT_EN
  logic        drop;
  logic [15:0] drop_cnt_q;

  assign drop = in_valid && !wr;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      drop_cnt_q <= '0;
    end else if (rearm_ok) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_rx_capture_ctrl.sv
// tb_rx_capture_ctrl: scoreboard bench with a queue-based reference
// model of capture, halt, drain and re-arm.
module tb_rx_capture_ctrl;

  localparam int DEPTH  = 64;
  localparam int HALT   = 48;
  localparam int FILL_W = 7;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        drain_en = 1'b0;
  logic        rearm = 1'b0;
  logic        m_tready = 1'b0;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic [31:0] status;
`ifdef RX_CAPTURE_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  int          m_fill = 0;
  bit          m_halted = 1'b0;
  int          m_drops = 0;

  rx_capture_ctrl #(
    .DEPTH      (DEPTH),
    .HALT_LEVEL (HALT),
    .FILL_W     (FILL_W)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .drain_en   (drain_en),
    .rearm      (rearm),
    .m_tvalid   (m_tvalid),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready),
    .status     (status)
`ifdef RX_CAPTURE_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: pops the expected word on every accepted transfer
  always @(negedge clk) begin
    logic [31:0] w;
    if (resetn && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_word: got %h expected none", m_tdata);
      end else begin
        w = exp_q.pop_front();
        chk("data", m_tdata, w);
        chk("tlast", 32'(m_tlast), 32'(m_fill == 1));
      end
    end
  end

  // reference model: status check, then advance to the next edge
  always begin
    logic [31:0] exp_st;
    bit wr, rd;
    int nf;
    @(negedge clk);
    #2;
    exp_st = {m_halted, (m_fill == 0), 13'b0, 17'(m_fill)};
    chk("status", status, exp_st);
`ifdef RX_CAPTURE_DROP_CNT_EN
    chk("drop_count", 32'(drop_count), 32'(m_drops));
`endif
    if (!resetn) begin
      m_fill = 0;
      m_halted = 1'b0;
      m_drops = 0;
      exp_q.delete();
    end else begin
      wr = in_valid && !m_halted && (m_fill < DEPTH);
      rd = m_tvalid && m_tready;
      if (wr) exp_q.push_back(in_data);
      nf = m_fill + int'(wr) - int'(rd);
      if (m_halted && rearm && !drain_en) begin
        m_halted = 1'b0;
        m_drops = 0;
      end else begin
        if (in_valid && !wr && m_drops < 65535) m_drops++;
        if (!m_halted && wr && nf >= HALT) m_halted = 1'b1;
      end
      m_fill = nf;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int n, input bit incr, input int base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data = incr ? 32'(base + i) : $urandom;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (status[30] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < budget), 32'd1);
  endtask

  initial begin
    repeat (3) tick();
    resetn = 1'b1;
    @(negedge clk);
    chk("reset_status", status, 32'h4000_0000);
    chk("reset_tvalid", 32'(m_tvalid), 32'd0);

    // fill to the halt level, then overrun with words to be dropped
    for (int i = 0; i < HALT + 10; i++) begin
      in_valid = 1'b1;
      in_data = (i < HALT) ? 32'(i) : 32'(32'h1000 + i);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("halt_status", status, 32'h8000_0030);
`ifdef RX_CAPTURE_DROP_CNT_EN
    chk("drops_10", 32'(drop_count), 32'd10);
`endif

    drain_en = 1'b1;
    m_tready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("rd_latency", 32'(m_tvalid), 32'd1);
    wait_empty(200);
    @(negedge clk);
    chk("drained_status", status, 32'hC000_0000);

    rearm = 1'b1;
    tick();
    rearm = 1'b0;
    @(negedge clk);
    chk("rearm_ignored", 32'(status[31]), 32'd1);

    drain_en = 1'b0;
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
    @(negedge clk);
    chk("rearm_status", status, 32'h4000_0000);
`ifdef RX_CAPTURE_DROP_CNT_EN
    chk("drops_clr", 32'(drop_count), 32'd0);
`endif
    stream(HALT, 1'b0, 0);
    @(negedge clk);
    chk("halt2_status", status, 32'h8000_0030);

    drain_en = 1'b1;
    m_tready = 1'b1;
    wait_empty(200);
    drain_en = 1'b0;
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
    tick();

    // random traffic: ready toggles each cycle, drain and rearm wander
    for (int i = 0; i < 800; i++) begin
      in_valid = 1'($urandom % 2);
      in_data = $urandom;
      m_tready = ~m_tready;
      if ($urandom % 16 == 0) drain_en = ~drain_en;
      rearm = ($urandom % 12 == 0);
      tick();
    end
    rearm = 1'b0;

    drain_en = 1'b0;
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
    stream(20, 1'b1, 32'h2000);
    drain_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data = 32'(32'h3000 + i);
      m_tready = ~m_tready;
      tick();
    end
    @(negedge clk);
    chk("pre_reset_nonempty", 32'(status[30]), 32'd0);
    resetn = 1'b0;
    in_valid = 1'b0;
    tick();
    resetn = 1'b1;
    @(negedge clk);
    chk("mid_reset_status", status, 32'h4000_0000);
    chk("mid_reset_tvalid", 32'(m_tvalid), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
